// File: rtl/program_loader_pkg.sv
// prog_loader_pkg: shared state encoding, fill word and fetch-index helper for the program loader
package prog_loader_pkg;
  typedef enum logic [2:0] {LOAD, RELEASE, RUN, DONE, ERROR} state_e;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  function automatic logic [13:0] word_index(input logic [15:0] addr);
    return addr[15:2];
  endfunction
endpackage

// File: rtl/program_loader_instr_ram.sv
// instr_ram: single-port synchronous instruction RAM with registered read
module instr_ram #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [IDX_W-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);
  logic [31:0] mem [DEPTH];
  // one port: loader writes during LOAD, core reads during RUN
  always_ff @(posedge clk_i) begin
    if (we_i) mem[addr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[addr_i];
  end
endmodule

// File: rtl/program_loader.sv
// program_loader: streams a program into instruction RAM, then releases the core and serves its fetches
module program_loader
  import prog_loader_pkg::*;
#(
  parameter int          DEPTH    = 1024,
  parameter int          IDX_W    = $clog2(DEPTH),
  parameter logic [31:0] NOP_WORD = prog_loader_pkg::NOP_WORD
) (
  input  logic           Clock,
  input  logic           nReset,
  input  logic           LoadValid,
  output logic           LoadReady,
  input  logic [31:0]    LoadData,
  input  logic           LoadLast,
  input  logic [15:0]    InstrAddr,
  output logic [31:0]    InstrMem,
  output logic           CpunReset,
  output logic           Done,
  output logic           Error,
  output logic [IDX_W:0] ProgWords
);
  state_e           state_q;
  logic [IDX_W:0]   count_q;
  logic             ready_q, cpu_rst_n_q, done_q, error_q, sel_q;
  logic [13:0]      widx_full;
  logic [IDX_W-1:0] widx;
  logic             fire, in_range, in_prog, hit;
  logic [31:0]      rdata;

  assign fire      = LoadValid & ready_q;
  assign widx_full = word_index(InstrAddr);
  assign widx      = widx_full[IDX_W-1:0];
  assign in_range  = (InstrAddr >> (IDX_W + 2)) == 16'd0;
  assign in_prog   = in_range && ({1'b0, widx} < count_q);
  assign hit       = {2'b00, widx_full} == 16'(count_q);

  instr_ram #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_ram (
    .clk_i   (Clock),
    .we_i    (fire),
    .re_i    (state_q == RUN),
    .addr_i  (state_q == LOAD ? count_q[IDX_W-1:0] : widx),
    .wdata_i (LoadData),
    .rdata_o (rdata)
  );

  // loader FSM: fill RAM, hold core in reset, release, serve fetches until the end-of-program fetch
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q     <= LOAD;
      count_q     <= '0;
      ready_q     <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      sel_q       <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          ready_q <= 1'b1;
          if (fire) begin
            count_q <= count_q + 1'b1;
            if (LoadLast) begin
              state_q <= RELEASE;
              ready_q <= 1'b0;
            end else if (count_q == (IDX_W + 1)'(DEPTH - 1)) begin
              state_q <= ERROR;
              ready_q <= 1'b0;
              error_q <= 1'b1;
            end
          end
        end
        RELEASE: begin
          state_q     <= RUN;
          cpu_rst_n_q <= 1'b1;
        end
        RUN: begin
          sel_q <= in_prog;
          if (hit) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            sel_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign LoadReady = ready_q;
  assign InstrMem  = sel_q ? rdata : NOP_WORD;
  assign CpunReset = cpu_rst_n_q;
  assign Done      = done_q;
  assign Error     = error_q;
  assign ProgWords = count_q;
endmodule
